// File: rtl/avalon_multi_timer_pkg.sv
// ----------------------------------------------------------------------------
// avalon_multi_timer_pkg : register map and bit positions of the timer
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package avalon_multi_timer_pkg;

  localparam logic [2:0] REG_STATUS   = 3'd0;
  localparam logic [2:0] REG_CONTROL  = 3'd1;
  localparam logic [2:0] REG_PERIOD   = 3'd2;
  localparam logic [2:0] REG_COMPARE  = 3'd3;
  localparam logic [2:0] REG_PRESCALE = 3'd4;
  localparam logic [2:0] REG_SNAP     = 3'd5;

  localparam int CTL_ITO   = 0;
  localparam int CTL_CONT  = 1;
  localparam int CTL_START = 2;
  localparam int CTL_STOP  = 3;
  localparam int CTL_PWM   = 4;
  localparam int CTL_W     = 5;

  localparam int ST_TO  = 0;
  localparam int ST_RUN = 1;

endpackage

`default_nettype wire

// File: rtl/avalon_multi_timer_ch.sv
// ----------------------------------------------------------------------------
// avalon_multi_timer_ch : one timer channel (registers, prescaler, counter,
// timeout flag and compare output)
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module avalon_multi_timer_ch
  import avalon_multi_timer_pkg::*;
#(
  parameter int          CNT_W        = 32,
  parameter int          PRE_W        = 16,
  parameter logic [31:0] RESET_PERIOD = 32'h0000C34F
) (
  input  logic        clk,
  input  logic        rst_i,
  input  logic        sel_i,
  input  logic        wr_i,
  input  logic [2:0]  reg_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        irq_o,
  output logic        pwm_o
);

  logic [CNT_W-1:0] period_q, period_d, cnt_q, cnt_d;
  logic [CNT_W-1:0] cmp_q, cmp_d, snap_q, snap_d;
  logic [PRE_W-1:0] pre_q, pre_d, pcnt_q, pcnt_d;
  logic [CTL_W-1:0] ctrl_q, ctrl_d;
  logic run_q, run_d, to_q, to_d, pwm_q, pwm_d;
  logic zero_q, force_q;

  logic w_wr_status, w_wr_ctrl, w_wr_period, w_wr_cmp, w_wr_pre, w_wr_snap;
  logic w_start, w_stop, w_tick, w_zero;

  always_comb begin
    w_wr_status = wr_i & sel_i & (reg_i == REG_STATUS);
    w_wr_ctrl   = wr_i & sel_i & (reg_i == REG_CONTROL);
    w_wr_period = wr_i & sel_i & (reg_i == REG_PERIOD);
    w_wr_cmp    = wr_i & sel_i & (reg_i == REG_COMPARE);
    w_wr_pre    = wr_i & sel_i & (reg_i == REG_PRESCALE);
    w_wr_snap   = wr_i & sel_i & (reg_i == REG_SNAP);
    w_start     = w_wr_ctrl & wdata_i[CTL_START];
    w_stop      = w_wr_ctrl & wdata_i[CTL_STOP];
    w_tick      = run_q & (pcnt_q == '0);
    w_zero      = (cnt_q == '0);
  end

  always_comb begin
    period_d = w_wr_period ? wdata_i[CNT_W-1:0] : period_q;
    cmp_d    = w_wr_cmp    ? wdata_i[CNT_W-1:0] : cmp_q;
    pre_d    = w_wr_pre    ? wdata_i[PRE_W-1:0] : pre_q;
    ctrl_d   = w_wr_ctrl   ? wdata_i[CTL_W-1:0] : ctrl_q;
    snap_d   = w_wr_snap   ? cnt_q              : snap_q;

    pcnt_d = pcnt_q;
    if (force_q)    pcnt_d = '0;
    else if (run_q) pcnt_d = w_tick ? pre_q : pcnt_q - PRE_W'(1);

    cnt_d = cnt_q;
    if (force_q)     cnt_d = period_q;
    else if (w_tick) cnt_d = w_zero ? period_q : cnt_q - CNT_W'(1);

    // START is applied last so it overrides every stop cause
    run_d = run_q;
    if (w_stop | force_q | (w_zero & w_tick & ~ctrl_q[CTL_CONT])) run_d = 1'b0;
    if (w_start) run_d = 1'b1;

    to_d = to_q;
    if (w_zero & ~zero_q) to_d = 1'b1;
    if (w_wr_status)      to_d = 1'b0;

    pwm_d = ctrl_q[CTL_PWM] & run_q & (cnt_q < cmp_q);
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      period_q <= RESET_PERIOD[CNT_W-1:0];
      cnt_q    <= RESET_PERIOD[CNT_W-1:0];
      cmp_q    <= '0;
      pre_q    <= '0;
      pcnt_q   <= '0;
      ctrl_q   <= '0;
      snap_q   <= '0;
      run_q    <= 1'b0;
      to_q     <= 1'b0;
      pwm_q    <= 1'b0;
      zero_q   <= 1'b0;
      force_q  <= 1'b0;
    end else begin
      period_q <= period_d;
      cnt_q    <= cnt_d;
      cmp_q    <= cmp_d;
      pre_q    <= pre_d;
      pcnt_q   <= pcnt_d;
      ctrl_q   <= ctrl_d;
      snap_q   <= snap_d;
      run_q    <= run_d;
      to_q     <= to_d;
      pwm_q    <= pwm_d;
      zero_q   <= w_zero;
      force_q  <= w_wr_period;
    end
  end

  always_comb begin
    rdata_o = '0;
    case (reg_i)
      REG_STATUS: begin
        rdata_o[ST_TO]  = to_q;
        rdata_o[ST_RUN] = run_q;
      end
      REG_CONTROL:  rdata_o[CTL_W-1:0] = ctrl_q;
      REG_PERIOD:   rdata_o[CNT_W-1:0] = period_q;
      REG_COMPARE:  rdata_o[CNT_W-1:0] = cmp_q;
      REG_PRESCALE: rdata_o[PRE_W-1:0] = pre_q;
      REG_SNAP:     rdata_o[CNT_W-1:0] = snap_q;
      default:      rdata_o = '0;
    endcase
  end

  assign irq_o = to_q & ctrl_q[CTL_ITO];
  assign pwm_o = pwm_q;

endmodule

`default_nettype wire

// File: rtl/avalon_multi_timer.sv
// ----------------------------------------------------------------------------
// avalon_multi_timer : multi-channel interval timer on an Avalon-MM slave
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module avalon_multi_timer
  import avalon_multi_timer_pkg::*;
#(
  parameter int          NUM_CH       = 4,
  parameter int          CNT_W        = 32,
  parameter int          PRE_W        = 16,
  parameter logic [31:0] RESET_PERIOD = 32'h0000C34F
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [3+$clog2(NUM_CH)-1:0]  address,
  input  logic                         chipselect,
  input  logic                         write_n,
  input  logic [31:0]                  writedata,
  output logic [31:0]                  readdata,
  output logic                         irq,
  output logic [NUM_CH-1:0]            pwm_out
);

  logic [3:0]        w_ch;
  logic [2:0]        w_reg;
  logic              w_wr;
  logic [31:0]       w_rd [NUM_CH];
  logic [NUM_CH-1:0] w_irq;
  logic [31:0]       readdata_q, readdata_d;

  // the shift keeps the channel field well-defined even when NUM_CH == 1
  assign w_ch  = 4'(address >> 3);
  assign w_reg = address[2:0];
  assign w_wr  = chipselect & ~write_n;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    avalon_multi_timer_ch #(
      .CNT_W        (CNT_W),
      .PRE_W        (PRE_W),
      .RESET_PERIOD (RESET_PERIOD)
    ) u_ch (
      .clk     (clk),
      .rst_i   (reset),
      .sel_i   (w_ch == 4'(i)),
      .wr_i    (w_wr),
      .reg_i   (w_reg),
      .wdata_i (writedata),
      .rdata_o (w_rd[i]),
      .irq_o   (w_irq[i]),
      .pwm_o   (pwm_out[i])
    );
  end

  always_comb begin
    readdata_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_ch == 4'(i)) readdata_d = w_rd[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) readdata_q <= '0;
    else       readdata_q <= readdata_d;
  end

  assign readdata = readdata_q;
  assign irq      = |w_irq;

endmodule

`default_nettype wire
